// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex segment table,
// inactive levels (active-high domain) and the digit-index width helper.
package seven_seg_pkg;

    // Bit order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic       DP_OFF  = 1'b0;
    localparam logic       AN_OFF  = 1'b0;

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high seven-segment pattern.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous
// value update, blanking, leading-zero suppression and anode guard time.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS    = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_load,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_start
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;

    logic [VAL_W-1:0]      r_pend_value;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic [NUM_DIGITS-1:0] r_pend_blank;
    logic                  r_pend_valid;

    logic [VAL_W-1:0]      r_disp_value;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [NUM_DIGITS-1:0] r_disp_blank;

    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_start;

    logic                  w_cnt_last;
    logic                  w_idx_last;
    logic                  w_swap;
    logic                  w_lit;
    logic [3:0]            w_nib;
    logic [6:0]            w_hex_seg;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic                  w_dark;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an;
    logic                  w_frame_start;

    assign w_cnt_last = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_swap     = w_cnt_last && w_idx_last && r_pend_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The swap reads the pending copy from before this edge, so a load on
    // the swap edge stays pending and is shown one frame later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '0;
        end else begin
            if (w_swap) begin
                r_disp_value <= r_pend_value;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
            end
            if (i_load) begin
                r_pend_value <= i_value;
                r_pend_dp    <= i_dp_in;
                r_pend_blank <= i_blank;
                r_pend_valid <= 1'b1;
            end else if (w_swap) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign w_nib = r_disp_value[{r_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nib (w_nib),
        .o_seg (w_hex_seg)
    );

    // w_upper_zero[i]: digit i and every more-significant digit are zero.
    always_comb begin
        logic zero_run;
        zero_run     = 1'b1;
        w_upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run        = zero_run && (r_disp_value[4*i +: 4] == 4'h0);
            w_upper_zero[i] = zero_run;
        end
    end

    assign w_dark = r_disp_blank[r_idx]
                  | ((LZ_SUPPRESS != 0) && (r_idx != '0) && w_upper_zero[r_idx]);
    assign w_seg  = w_dark ? SEG_OFF : w_hex_seg;
    assign w_dp   = r_disp_blank[r_idx] ? DP_OFF : r_disp_dp[r_idx];
    assign w_lit  = (r_cnt >= CNT_W'(GUARD));
    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

    always_comb begin
        w_an        = {NUM_DIGITS{AN_OFF}};
        w_an[r_idx] = w_lit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg         <= SEG_OFF;
            r_dp          <= DP_OFF;
            r_an          <= {NUM_DIGITS{AN_OFF}};
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg;
            r_dp          <= w_dp;
            r_an          <= w_an;
            r_frame_start <= w_frame_start;
        end
    end

    // Registers hold active-high levels; board polarity is applied here.
    assign o_seg         = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign o_dp          = (SEG_ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign o_an          = (AN_ACTIVE_LOW  != 0) ? ~r_an  : r_an;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: three instances (plain, leading-zero suppressed,
// active-low segments) checked every cycle against a frame-level model.
module tb_seven_seg_scan;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int GD    = 1;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;

    logic [6:0] seg_m, seg_l, seg_a;
    logic       dp_m, dp_l, dp_a;
    logic [3:0] an_m, an_l, an_a;
    logic       fs_m, fs_l, fs_a;

    out_t a_main, a_lz, a_al;
    out_t e_main, e_lz, e_al;

    assign a_main = {seg_m, dp_m, an_m, fs_m};
    assign a_lz   = {seg_l, dp_l, an_l, fs_l};
    assign a_al   = {seg_a, dp_a, an_a, fs_a};

    int total = 0;
    int bad   = 0;

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: cycles since reset, shown value, pending value.
    int          m_pos = 0;
    logic [15:0] m_dv = '0, m_pv_v = '0;
    logic [3:0]  m_dp = '0, m_bl = '0, m_pv_dp = '0, m_pv_bl = '0;
    bit          m_pv = 1'b0;
    int          last_pos = 0;
    logic [15:0] last_dv = '0;
    logic [3:0]  last_bl = '0;

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(0)) dut_main (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp_in(dp_in), .i_blank(blank),
        .i_load(load), .o_seg(seg_m), .o_dp(dp_m), .o_an(an_m), .o_frame_start(fs_m));

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)) dut_lz (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp_in(dp_in), .i_blank(blank),
        .i_load(load), .o_seg(seg_l), .o_dp(dp_l), .o_an(an_l), .o_frame_start(fs_l));

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(0)) dut_al (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp_in(dp_in), .i_blank(blank),
        .i_load(load), .o_seg(seg_a), .o_dp(dp_a), .o_an(an_a), .o_frame_start(fs_a));

    function automatic out_t off_out(input bit al);
        out_t o;
        o.seg = al ? 7'h7F : 7'h00;
        o.dp  = al;
        o.an  = 4'hF;
        o.fs  = 1'b0;
        return o;
    endfunction

    function automatic out_t model_out(input int pos, input logic [15:0] dv,
                                       input logic [3:0] ddp, input logic [3:0] dbl,
                                       input bit lz, input bit al);
        int         slot = (pos / RD) % ND;
        int         c    = pos % RD;
        logic [3:0] dig  = 4'((dv >> (4 * slot)) & 16'hF);
        bit         dark = dbl[slot] || (lz && slot >= 1 && (dv >> (4 * slot)) == 16'h0);
        out_t       o;
        o.seg = dark ? 7'h00 : hex_tab[dig];
        o.dp  = ddp[slot] && !dbl[slot];
        o.an  = (c >= GD) ? ~(4'b0001 << slot) : 4'hF;
        o.fs  = (pos % FRAME) == 0;
        if (al) begin
            o.seg = ~o.seg;
            o.dp  = ~o.dp;
        end
        return o;
    endfunction

    // One clock edge: predict outputs from pre-edge model state, then advance.
    task automatic tick();
        if (rst) begin
            e_main = off_out(0);
            e_lz   = off_out(0);
            e_al   = off_out(1);
        end else begin
            e_main = model_out(m_pos, m_dv, m_dp, m_bl, 0, 0);
            e_lz   = model_out(m_pos, m_dv, m_dp, m_bl, 1, 0);
            e_al   = model_out(m_pos, m_dv, m_dp, m_bl, 0, 1);
        end
        last_pos = m_pos;
        last_dv  = m_dv;
        last_bl  = m_bl;
        if (rst) begin
            m_pos = 0; m_dv = '0; m_dp = '0; m_bl = '0;
            m_pv = 0; m_pv_v = '0; m_pv_dp = '0; m_pv_bl = '0;
        end else begin
            if ((m_pos % FRAME) == FRAME - 1 && m_pv) begin
                m_dv = m_pv_v; m_dp = m_pv_dp; m_bl = m_pv_bl; m_pv = 0;
            end
            if (load) begin
                m_pv_v = value; m_pv_dp = dp_in; m_pv_bl = blank; m_pv = 1;
            end
            m_pos++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL reset_state got=%h/%h/%h exp=%h/%h/%h", a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
        end
        total++;
        if (an_m !== 4'hF || seg_m !== 7'h00 || fs_m !== 1'b0) begin
            bad++;
            $display("FAIL reset_literal an=%h seg=%h fs=%b exp an=f seg=00 fs=0", an_m, seg_m, fs_m);
        end
        rst = 1'b0;
        tick();
        total++;
        if (fs_m !== 1'b1 || {a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
            bad++;
            $display("FAIL reset_release fs=%b got=%h exp=%h", fs_m, a_main, e_main);
        end
    endtask

    task automatic test_basic_scan();
        logic [6:0] ls [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        int slot;
        value = 16'h1234; dp_in = '0; blank = '0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL basic_scan pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            slot = (last_pos / RD) % ND;
            if (last_dv == 16'h1234 && (last_pos % RD) == GD) begin
                total++;
                if (seg_m !== ls[slot] || an_m !== ~(4'b0001 << slot)) begin
                    bad++;
                    $display("FAIL basic_slot%0d seg=%h an=%b exp seg=%h", slot, seg_m, an_m, ls[slot]);
                end
            end
            if (last_dv == 16'h1234 && (last_pos % RD) == 0) begin
                total++;
                if (an_m !== 4'hF) begin
                    bad++;
                    $display("FAIL basic_guard an=%b exp=1111", an_m);
                end
            end
        end
    endtask

    task automatic test_latest_wins();
        for (int k = 0; k < FRAME && (m_pos % FRAME) != 2; k++) tick();
        value = 16'hABCD; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        value = 16'hEF01; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL latest_wins pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            if (((last_pos / RD) % ND) == 3 && (last_pos % RD) >= GD) begin
                total++;
                if (seg_m === 7'h77) begin
                    bad++;
                    $display("FAIL latest_wins_stale seg=%h must not be 77", seg_m);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] ls [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
        logic [3:0] ld = 4'b1000;
        int slot;
        value = 16'h0050; dp_in = 4'b1000; blank = '0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL lz_scan pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            slot = (last_pos / RD) % ND;
            if (last_dv == 16'h0050 && (last_pos % RD) == GD) begin
                total++;
                if (seg_l !== ls[slot] || dp_l !== ld[slot]) begin
                    bad++;
                    $display("FAIL lz_digit%0d seg=%h dp=%b exp seg=%h dp=%b", slot, seg_l, dp_l, ls[slot], ld[slot]);
                end
            end
        end
        value = 16'h0000; dp_in = '0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL lz_zero pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            slot = (last_pos / RD) % ND;
            if (last_dv == 16'h0000 && (last_pos % RD) == GD && slot <= 1) begin
                total++;
                if (seg_l !== ((slot == 0) ? 7'h3F : 7'h00)) begin
                    bad++;
                    $display("FAIL lz_zero_digit%0d seg=%h", slot, seg_l);
                end
            end
        end
    endtask

    task automatic test_blank_and_polarity();
        int slot;
        value = 16'($urandom_range(0, 16'hFFFF)); dp_in = 4'b0010; blank = 4'b0010; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL blank_scan pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            slot = (last_pos / RD) % ND;
            if (last_bl == 4'b0010 && slot == 1 && (last_pos % RD) == GD) begin
                total++;
                if (seg_m !== 7'h00 || dp_m !== 1'b0) begin
                    bad++;
                    $display("FAIL blank_digit1 seg=%h dp=%b exp 00/0", seg_m, dp_m);
                end
            end
        end
        value = 16'h8888; dp_in = '0; blank = '0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL polarity_scan pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            if (last_dv == 16'h8888 && (last_pos % RD) == GD) begin
                total++;
                if (seg_a !== 7'h00 || dp_a !== 1'b1) begin
                    bad++;
                    $display("FAIL active_low_8 seg=%h dp=%b exp 00/1", seg_a, dp_a);
                end
            end
        end
    endtask

    task automatic test_swap_edge();
        value = 16'h1111; dp_in = '0; blank = '0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 36; k++) tick();
        for (int k = 0; k < FRAME && (m_pos % FRAME) != FRAME - 1; k++) tick();
        value = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        for (int j = 0; j < 32; j++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL swap_edge pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            if ((last_pos % RD) == GD) begin
                total++;
                if (seg_m !== ((j < FRAME) ? 7'h06 : 7'h5B)) begin
                    bad++;
                    $display("FAIL swap_edge_frame j=%0d seg=%h", j, seg_m);
                end
            end
        end
    endtask

    task automatic test_frame_start();
        int gap;
        bit seen;
        seen = 0;
        for (int k = 0; k < 2 * FRAME && !seen; k++) begin
            tick();
            seen = (fs_m === 1'b1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL frame_start_timeout no pulse within %0d cycles", 2 * FRAME);
        end
        for (int r = 0; r < 2; r++) begin
            gap  = 0;
            seen = 0;
            for (int k = 0; k < 2 * FRAME && !seen; k++) begin
                tick();
                gap++;
                seen = (fs_m === 1'b1);
                total++;
                if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                    bad++;
                    $display("FAIL frame_scan pos=%0d got=%h exp=%h", last_pos, a_main, e_main);
                end
            end
            total++;
            if (!seen || gap != FRAME) begin
                bad++;
                $display("FAIL frame_spacing gap=%0d exp=%0d", gap, FRAME);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < FRAME && (m_pos % FRAME) != 9; k++) tick();
        value = 16'h9876; dp_in = 4'b0101; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (an_m !== 4'hF || seg_m !== 7'h00 || {a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
            bad++;
            $display("FAIL reset_mid an=%b seg=%h exp 1111/00", an_m, seg_m);
        end
        tick();
        total++;
        if (fs_m !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_restart fs=%b exp=1", fs_m);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL reset_mid_scan pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
            if ((last_pos % RD) == GD) begin
                total++;
                if (seg_m !== 7'h3F || dp_m !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_zero seg=%h dp=%b exp 3f/0", seg_m, dp_m);
                end
            end
        end
    endtask

    task automatic test_random();
        int gap;
        for (int n = 0; n < 25; n++) begin
            gap = $urandom_range(0, 20);
            for (int k = 0; k < gap; k++) begin
                rst = ($urandom_range(0, 60) == 0);
                tick();
                rst = 1'b0;
                total++;
                if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                    bad++;
                    $display("FAIL random_scan pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
                end
            end
            value = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
            dp_in = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            load  = 1'b1;
            tick();
            load  = 1'b0;
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL random_load pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
        end
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            tick();
            total++;
            if ({a_main, a_lz, a_al} !== {e_main, e_lz, e_al}) begin
                bad++;
                $display("FAIL random_tail pos=%0d got=%h/%h/%h exp=%h/%h/%h", last_pos, a_main, a_lz, a_al, e_main, e_lz, e_al);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_latest_wins();
        test_lz();
        test_blank_and_polarity();
        test_swap_edge();
        test_frame_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
